map_renderer: RTL and testbench
===============================

# map_renderer

Sequential read-side client of the map RAM controller. On a `start` pulse it walks every map cell in row-major order, reads the 3-bit sprite code at (x, y), and expands it into a CELL×CELL block of pixel writes for the downstream VGA adapter. It runs one plot per clock, and each frame redraw is a single non-overlapping pass.

## Interface
Parameters:
- `MAP_W`, default 20: map columns. Must match the controller address stride of 20.
- `MAP_H`, default 21: map rows.
- `CELL`, default 5: pixels per cell edge.
- `RD_LAT`, default 1: map RAM read latency in clocks, ≥1.

Ports:
- `clock_50`, in, 1: system clock. One clock domain.
- `reset_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: single-cycle request to redraw the full map.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse after the last pixel of the last cell.
- `map_x`, out, 5: cell column to the map controller.
- `map_y`, out, 5: cell row to the map controller.
- `readwrite`, out, 1: constant 0. The renderer never writes.
- `sprite_data_in`, in, 3: sprite code returned by the map controller.
- `vga_x`, out, 8: pixel x = map_x·CELL + px.
- `vga_y`, out, 7: pixel y = map_y·CELL + py.
- `colour`, out, 3: RGB pixel colour.
- `plot`, out, 1: pixel write strobe. `vga_x`, `vga_y` and `colour` are valid while `plot`=1.

## Operation
Sprite codes map to pixel patterns as follows:
- 0 EMPTY: all pixels black (000).
- 1 WALL: all pixels blue (001).
- 2 PELLET: centre pixel only is white (111); all other pixels are black.
- 3 POWER: the centre 3×3 pixels are white; all other pixels are black.
- 4 PACMAN: all pixels yellow (110).
- 5 GHOST: all pixels red (100).
- 6, 7 (reserved): all pixels magenta (101), which marks corrupt map data.

Every pixel of a cell is plotted, including the black ones, so that stale content is erased.

FSM states:
- IDLE: when `start`=1, clear x, y, px, py → ADDR. Otherwise stay.
- ADDR: drive `map_x`/`map_y`, load the wait counter with RD_LAT → WAIT.
- WAIT: decrement the counter. On the last wait cycle, latch `sprite_data_in` into a code register → DRAW.
- DRAW: `plot`=1 every cycle. Advance px, and on px=CELL−1 advance py. On px=py=CELL−1 → NEXT.
- NEXT: advance x, and on x=MAP_W−1 wrap x to 0 and advance y. If the finished cell was (MAP_W−1, MAP_H−1) → FIN, else → ADDR.
- FIN: `done`=1 for one cycle → IDLE.

Rules:
- `map_x`/`map_y` are held stable from ADDR through NEXT of the same cell.
- `start` while `busy` is ignored. It is not queued.
- `start` is sampled only in IDLE.
- Width rule: `vga_x` = {3'b0,x}·CELL + px, computed at 8 bits; `vga_y` is computed at 7 bits. The parameter limits MAP_W·CELL ≤ 256 and MAP_H·CELL ≤ 128 are checked by elaboration assertion.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0. Reset is asynchronous and takes effect mid-frame, with no `done` pulse. The next `start` restarts at cell (0,0).
- `start` in cycle T → state ADDR in T+1; `busy` rises at T+1.
- Cycles per cell = 1 (ADDR) + RD_LAT (WAIT) + CELL² (DRAW) + 1 (NEXT).
  - With defaults this is 28 cycles per cell.
  - A frame is 420·28 = 11760 cycles, and `done` asserts in cycle T+11761.
- `busy` falls in the same cycle as `done`.
- `plot` is never asserted outside DRAW. `plot` is registered, and `vga_x`/`vga_y`/`colour` are registered together with it, with zero skew between them.

## Structure
- Package `map_pkg`, holding:
  - sprite code constants (EMPTY…GHOST);
  - 3-bit colour constants;
  - defaults for MAP_W, MAP_H and CELL;
  - the FSM state enum.

  The map controller and game logic share this package.
- Sub-module `cell_pattern`: purely combinational, (code, px, py) → colour. It contains the pattern table, so new sprites touch only this module.

## Test plan
- Memory model with RD_LAT=1, all cells WALL; one `start` → 10500 plots, all with `colour`=001, then exactly one `done` 11760 cycles after `busy` rises.
- Cell (3,2)=PELLET, all others EMPTY → the only non-black plot is at (17,12) with colour 111.
- Cell (0,0)=POWER → white plots exactly at x,y ∈ {1,2,3}, 9 pixels in total.
- Cell code 7 → all 25 plots of that cell are 101. RD_LAT=2 → the frame takes 12180 cycles and the data latched for each cell is correct.
- `start` re-pulsed mid-frame → ignored, and the frame length is unchanged. `reset_n` low at cycle 5000 → all outputs 0 asynchronously, no `done`. Next `start` → first plot at (0,0).
- Check every cycle: `readwrite`=0; `map_x`/`map_y` constant while `plot`=1; `vga_x` < 100; `vga_y` < 105.

Source files
------------

// File: rtl/map_pkg.sv
// Shared definitions for the map subsystem: sprite codes, pixel colours,
// default geometry and the renderer FSM state encoding.
package map_pkg;

  localparam int MAP_W_DEF = 20;
  localparam int MAP_H_DEF = 21;
  localparam int CELL_DEF  = 5;

  localparam logic [2:0] SP_EMPTY  = 3'd0;
  localparam logic [2:0] SP_WALL   = 3'd1;
  localparam logic [2:0] SP_PELLET = 3'd2;
  localparam logic [2:0] SP_POWER  = 3'd3;
  localparam logic [2:0] SP_PACMAN = 3'd4;
  localparam logic [2:0] SP_GHOST  = 3'd5;

  localparam logic [2:0] C_BLACK   = 3'b000;
  localparam logic [2:0] C_BLUE    = 3'b001;
  localparam logic [2:0] C_WHITE   = 3'b111;
  localparam logic [2:0] C_YELLOW  = 3'b110;
  localparam logic [2:0] C_RED     = 3'b100;
  localparam logic [2:0] C_MAGENTA = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_DRAW,
    S_NEXT,
    S_FIN
  } state_t;

endpackage

// File: rtl/cell_pattern.sv
// Combinational sprite pattern table: (code, px, py) -> pixel colour.
// Adding a sprite only touches this module.
module cell_pattern
  import map_pkg::*;
#(
  parameter int CELL = CELL_DEF,
  parameter int PW   = 3
) (
  input  logic [2:0]    code,
  input  logic [PW-1:0] px,
  input  logic [PW-1:0] py,
  output logic [2:0]    colour
);

  localparam int CTR = CELL / 2;

  logic at_ctr;
  logic in_core;

  always_comb begin
    at_ctr  = (int'(px) == CTR) && (int'(py) == CTR);
    // 3x3 block centred on the cell for power pellets
    in_core = (int'(px) >= CTR - 1) && (int'(px) <= CTR + 1) &&
              (int'(py) >= CTR - 1) && (int'(py) <= CTR + 1);
    case (code)
      SP_EMPTY:  colour = C_BLACK;
      SP_WALL:   colour = C_BLUE;
      SP_PELLET: colour = at_ctr ? C_WHITE : C_BLACK;
      SP_POWER:  colour = in_core ? C_WHITE : C_BLACK;
      SP_PACMAN: colour = C_YELLOW;
      SP_GHOST:  colour = C_RED;
      default:   colour = C_MAGENTA;
    endcase
  end

endmodule

// File: rtl/map_renderer.sv
// Walks the map in row-major order, reads each cell's sprite code and
// plots a CELL x CELL pixel block per cell, one pixel per clock.
module map_renderer
  import map_pkg::*;
#(
  parameter int MAP_W  = MAP_W_DEF,
  parameter int MAP_H  = MAP_H_DEF,
  parameter int CELL   = CELL_DEF,
  parameter int RD_LAT = 1
) (
  input  logic       clock_50,
  input  logic       reset_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [4:0] map_x,
  output logic [4:0] map_y,
  output logic       readwrite,
  input  logic [2:0] sprite_data_in,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot
);

  localparam int            PW   = (CELL > 1) ? $clog2(CELL) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CELL - 1);
  localparam logic [4:0]    XMAX = 5'(MAP_W - 1);
  localparam logic [4:0]    YMAX = 5'(MAP_H - 1);
  localparam logic [7:0]    WLAT = 8'(RD_LAT);

  if ((MAP_W * CELL > 256) || (MAP_H * CELL > 128) || (MAP_W > 32) ||
      (MAP_H > 32) || (RD_LAT < 1) || (RD_LAT > 255)) begin : g_param_check
    $error("map_renderer: unsupported parameter combination");
  end

  // Handshake: start is a one-cycle request sampled only in IDLE; busy is
  // high from the cycle after acceptance until done, which pulses for one
  // cycle as busy falls. start while busy is dropped, not queued.

  state_t        state;
  logic [PW-1:0] px;
  logic [PW-1:0] py;
  logic [7:0]    wait_cnt;
  logic [2:0]    code;

  logic          first_pix;
  logic          last_pix;
  logic [PW-1:0] nx_px;
  logic [PW-1:0] nx_py;
  logic [2:0]    pat_code;
  logic [2:0]    pat_colour;
  logic [7:0]    nx_vga_x;
  logic [6:0]    nx_vga_y;

  assign readwrite = 1'b0;

  // Pixel to be presented on the next clock; pixel (0,0) uses the read data
  // directly because the code register loads on that same edge.
  always_comb begin
    first_pix = (state == S_WAIT);
    last_pix  = (px == PMAX) && (py == PMAX);
    nx_px     = '0;
    nx_py     = '0;
    if (!first_pix) begin
      if (px == PMAX) begin
        nx_px = '0;
        nx_py = py + 1'b1;
      end else begin
        nx_px = px + 1'b1;
        nx_py = py;
      end
    end
    pat_code = first_pix ? sprite_data_in : code;
    nx_vga_x = {3'b000, map_x} * 8'(CELL) + 8'(nx_px);
    nx_vga_y = {2'b00, map_y} * 7'(CELL) + 7'(nx_py);
  end

  cell_pattern #(
    .CELL (CELL),
    .PW   (PW)
  ) u_cell_pattern (
    .code   (pat_code),
    .px     (nx_px),
    .py     (nx_py),
    .colour (pat_colour)
  );

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      px       <= '0;
      py       <= '0;
      wait_cnt <= '0;
      code     <= '0;
      map_x    <= '0;
      map_y    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      vga_x    <= '0;
      vga_y    <= '0;
      colour   <= '0;
      plot     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            map_x <= '0;
            map_y <= '0;
            px    <= '0;
            py    <= '0;
            busy  <= 1'b1;
            state <= S_ADDR;
          end
        end
        S_ADDR: begin
          wait_cnt <= WLAT;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 8'd1;
          if (wait_cnt == 8'd1) begin
            code   <= sprite_data_in;
            plot   <= 1'b1;
            vga_x  <= nx_vga_x;
            vga_y  <= nx_vga_y;
            colour <= pat_colour;
            state  <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (last_pix) begin
            px     <= '0;
            py     <= '0;
            plot   <= 1'b0;
            vga_x  <= '0;
            vga_y  <= '0;
            colour <= '0;
            state  <= S_NEXT;
          end else begin
            px     <= nx_px;
            py     <= nx_py;
            plot   <= 1'b1;
            vga_x  <= nx_vga_x;
            vga_y  <= nx_vga_y;
            colour <= pat_colour;
          end
        end
        S_NEXT: begin
          if (map_x == XMAX) begin
            map_x <= '0;
            if (map_y == YMAX) begin
              map_y <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              map_y <= map_y + 5'd1;
              state <= S_ADDR;
            end
          end else begin
            map_x <= map_x + 5'd1;
            state <= S_ADDR;
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_map_renderer.sv
// Bench for map_renderer: RAM models with latency 1 and 2, a pixel-order
// reference model feeding expected queues, and per-cycle invariant checks.
module tb_map_renderer;

  localparam int MW    = 20;
  localparam int MH    = 21;
  localparam int CS    = 5;
  localparam int NCELL = MW * MH;

  // clock / reset
  logic clock_50 = 1'b0;
  always #5 clock_50 = ~clock_50;

  logic       reset_n;
  logic       start;
  logic       start2;

  logic       busy, done, readwrite, plot;
  logic [4:0] map_x, map_y;
  logic [2:0] sprite_data_in, colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;

  logic       busy2, done2, readwrite2, plot2;
  logic [4:0] map_x2, map_y2;
  logic [2:0] sprite_data_in2, colour2;
  logic [7:0] vga_x2;
  logic [6:0] vga_y2;

  map_renderer #(.MAP_W(MW), .MAP_H(MH), .CELL(CS), .RD_LAT(1)) dut (
    .clock_50(clock_50), .reset_n(reset_n), .start(start), .busy(busy),
    .done(done), .map_x(map_x), .map_y(map_y), .readwrite(readwrite),
    .sprite_data_in(sprite_data_in), .vga_x(vga_x), .vga_y(vga_y),
    .colour(colour), .plot(plot)
  );

  map_renderer #(.MAP_W(MW), .MAP_H(MH), .CELL(CS), .RD_LAT(2)) dut2 (
    .clock_50(clock_50), .reset_n(reset_n), .start(start2), .busy(busy2),
    .done(done2), .map_x(map_x2), .map_y(map_y2), .readwrite(readwrite2),
    .sprite_data_in(sprite_data_in2), .vga_x(vga_x2), .vga_y(vga_y2),
    .colour(colour2), .plot(plot2)
  );

  // map RAM models
  logic [2:0] map_mem [NCELL];
  logic [2:0] rd2_stage;

  function automatic logic [2:0] rd(input logic [4:0] x, input logic [4:0] y);
    if (int'(x) < MW && int'(y) < MH) return map_mem[int'(y) * MW + int'(x)];
    return 3'd0;
  endfunction

  always @(posedge clock_50) begin
    sprite_data_in  <= rd(map_x, map_y);
    rd2_stage       <= rd(map_x2, map_y2);
    sprite_data_in2 <= rd2_stage;
  end

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [17:0] exp_q[$];
  logic [17:0] exp2_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // reference pixel colour straight from the sprite rules
  function automatic logic [2:0] exp_colour(input logic [2:0] c, input int px, input int py);
    bit centre = (px == CS / 2) && (py == CS / 2);
    bit core   = (px >= CS / 2 - 1) && (px <= CS / 2 + 1) &&
                 (py >= CS / 2 - 1) && (py <= CS / 2 + 1);
    case (c)
      3'd0:    return 3'b000;
      3'd1:    return 3'b001;
      3'd2:    return centre ? 3'b111 : 3'b000;
      3'd3:    return core ? 3'b111 : 3'b000;
      3'd4:    return 3'b110;
      3'd5:    return 3'b100;
      default: return 3'b101;
    endcase
  endfunction

  task automatic load_frame(input bit second);
    logic [17:0] e;
    for (int y = 0; y < MH; y++)
      for (int x = 0; x < MW; x++)
        for (int py = 0; py < CS; py++)
          for (int px = 0; px < CS; px++) begin
            e = {8'(x * CS + px), 7'(y * CS + py),
                 exp_colour(map_mem[y * MW + x], px, py)};
            if (second) exp2_q.push_back(e);
            else exp_q.push_back(e);
          end
  endtask

  // monitor for the RD_LAT=1 instance
  int cyc = 0;
  int plot_cnt, done_cnt, white_cnt, mag_cnt, nb_cnt;
  int busy_rise, done_cyc, first_x, first_y, nb_x, nb_y;
  logic prev_plot = 1'b0, prev_busy = 1'b0;
  logic [4:0] prev_mx, prev_my;
  logic [17:0] got1, want1;

  always @(negedge clock_50) begin
    cyc++;
    if (reset_n) begin
      chk("readwrite", 32'(readwrite), 32'd0);
      chk("vga_x_range", 32'(vga_x < 8'd100), 32'd1);
      chk("vga_y_range", 32'(vga_y < 7'd105), 32'd1);
      if (plot) begin
        if (plot_cnt == 0) begin first_x = vga_x; first_y = vga_y; end
        plot_cnt++;
        if (colour == 3'b111) white_cnt++;
        if (colour == 3'b101) mag_cnt++;
        if (colour != 3'b000) begin nb_cnt++; nb_x = vga_x; nb_y = vga_y; end
        if (prev_plot) begin
          chk("map_x_stable", 32'(map_x), 32'(prev_mx));
          chk("map_y_stable", 32'(map_y), 32'(prev_my));
        end
        chk("pixel_in_cell_x", 32'(vga_x) / CS, 32'(map_x));
        got1 = {vga_x, vga_y, colour};
        chk("plots_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          want1 = exp_q.pop_front();
          chk("pixel", 32'(got1), 32'(want1));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_low_at_done", 32'(busy), 32'd0);
        chk("busy_high_before_done", 32'(prev_busy), 32'd1);
      end
      if (busy && !prev_busy) busy_rise = cyc;
    end
    prev_plot = plot;
    prev_busy = busy;
    prev_mx   = map_x;
    prev_my   = map_y;
  end

  // monitor for the RD_LAT=2 instance
  int plot2_cnt, done2_cnt, busy2_rise, done2_cyc;
  logic prev_busy2 = 1'b0;
  logic [17:0] want2;

  always @(negedge clock_50) begin
    if (reset_n) begin
      chk("readwrite2", 32'(readwrite2), 32'd0);
      if (plot2) begin
        plot2_cnt++;
        chk("plots_expected2", 32'(exp2_q.size() > 0), 32'd1);
        if (exp2_q.size() > 0) begin
          want2 = exp2_q.pop_front();
          chk("pixel2", 32'({vga_x2, vga_y2, colour2}), 32'(want2));
        end
      end
      if (done2) begin
        done2_cnt++;
        done2_cyc = cyc;
      end
      if (busy2 && !prev_busy2) busy2_rise = cyc;
    end
    prev_busy2 = busy2;
  end

  // driver tasks
  task automatic begin_frame(input bit second);
    plot_cnt = 0; done_cnt = 0; white_cnt = 0; mag_cnt = 0; nb_cnt = 0;
    busy_rise = -1; plot2_cnt = 0; done2_cnt = 0; busy2_rise = -1;
    first_x = -1; first_y = -1;
    load_frame(second);
    @(negedge clock_50);
    if (second) start2 = 1'b1;
    else start = 1'b1;
    @(negedge clock_50);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input bit second, input int budget);
    int n = 0;
    while (((second ? done2_cnt : done_cnt) == 0) && n < budget) begin
      @(negedge clock_50); #1;
      n++;
    end
    chk("done_within_budget", 32'((second ? done2_cnt : done_cnt) > 0), 32'd1);
    repeat (4) @(negedge clock_50);
    #1;
  endtask

  task automatic end_frame(input bit second, input int exp_len);
    if (second) begin
      chk("frame_length2", 32'(done2_cyc - busy2_rise), 32'(exp_len));
      chk("done_count2", 32'(done2_cnt), 32'd1);
      chk("plot_count2", 32'(plot2_cnt), 32'(NCELL * CS * CS));
      chk("queue_drained2", 32'(exp2_q.size()), 32'd0);
    end else begin
      chk("frame_length", 32'(done_cyc - busy_rise), 32'(exp_len));
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("plot_count", 32'(plot_cnt), 32'(NCELL * CS * CS));
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic fill_map(input int mode);
    for (int i = 0; i < NCELL; i++)
      map_mem[i] = (mode == 0) ? 3'd0 : (mode == 1) ? 3'd1 : 3'($urandom_range(0, 7));
  endtask

  // directed sequence
  initial begin
    int n;
    reset_n = 1'b0;
    start   = 1'b0;
    start2  = 1'b0;
    fill_map(0);
    repeat (3) @(negedge clock_50);
    chk("reset_outputs", 32'({busy, done, map_x, map_y, vga_x, vga_y, colour, plot}), 32'd0);
    chk("reset_outputs2", 32'({busy2, done2, map_x2, map_y2, vga_x2, vga_y2, colour2, plot2}), 32'd0);
    reset_n = 1'b1;

    // all walls: every plot blue
    fill_map(1);
    begin_frame(1'b0);
    wait_done(1'b0, 12500);
    end_frame(1'b0, 11760);

    // single pellet at cell (3,2)
    fill_map(0);
    map_mem[2 * MW + 3] = 3'd2;
    begin_frame(1'b0);
    wait_done(1'b0, 12500);
    end_frame(1'b0, 11760);
    chk("pellet_nonblack_count", 32'(nb_cnt), 32'd1);
    chk("pellet_pos", 32'({8'(nb_x), 7'(nb_y)}), 32'({8'd17, 7'd12}));

    // power pellet at (0,0), corrupt code at (5,4), start re-pulsed mid-frame
    fill_map(0);
    map_mem[0] = 3'd3;
    map_mem[4 * MW + 5] = 3'd7;
    begin_frame(1'b0);
    repeat (3000) @(negedge clock_50);
    start = 1'b1;
    @(negedge clock_50);
    start = 1'b0;
    wait_done(1'b0, 12500);
    end_frame(1'b0, 11760);
    chk("power_white_count", 32'(white_cnt), 32'd9);
    chk("corrupt_magenta_count", 32'(mag_cnt), 32'd25);

    // asynchronous reset partway through a frame
    fill_map(2);
    begin_frame(1'b0);
    n = 0;
    while ((busy_rise < 0 || cyc - busy_rise < 5000) && n < 6000) begin
      @(negedge clock_50); #1;
      n++;
    end
    chk("reached_cycle_5000", 32'(n < 6000), 32'd1);
    @(posedge clock_50);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({busy, done, map_x, map_y, vga_x, vga_y, colour, plot}), 32'd0);
    repeat (3) @(negedge clock_50);
    chk("no_done_after_reset", 32'(done_cnt), 32'd0);
    exp_q.delete();
    reset_n = 1'b1;

    // fresh random frame after reset restarts at cell (0,0)
    fill_map(2);
    begin_frame(1'b0);
    wait_done(1'b0, 12500);
    end_frame(1'b0, 11760);
    chk("first_plot_after_reset", 32'({8'(first_x), 7'(first_y)}), 32'd0);

    // read latency 2
    fill_map(2);
    begin_frame(1'b1);
    wait_done(1'b1, 13000);
    end_frame(1'b1, 12180);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
